// File: rtl/program_sender.sv
// Host-side boot loader feeder: streams sync byte 0xAA and a zero-terminated
// 32-bit program image MSB-first over a UART to the CPU serial boot loader.

module uart_tx #(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_start,
    input  logic [7:0] data,
    output logic       tx_busy,
    output logic       txd
);
    localparam int unsigned BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int unsigned CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

    logic [CW-1:0] cnt;
    logic [9:0]    frame;
    logic [3:0]    bits_left;

    // 8N1 frame, LSB first; tx_busy drops when the stop bit has completed
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_busy   <= 1'b0;
            txd       <= 1'b1;
            cnt       <= '0;
            frame     <= '1;
            bits_left <= '0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                frame     <= {1'b1, data, 1'b0};
                txd       <= 1'b0;
                tx_busy   <= 1'b1;
                cnt       <= '0;
                bits_left <= 4'd10;
            end
        end else if (cnt == CW'(BIT_CYC - 1)) begin
            cnt       <= '0;
            frame     <= {1'b1, frame[9:1]};
            bits_left <= bits_left - 4'd1;
            if (bits_left == 4'd1) begin
                tx_busy <= 1'b0;
                txd     <= 1'b1;
            end else begin
                txd <= frame[1];
            end
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

module program_sender #(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int PROG_SIZE        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 prog_we,
    input  logic [PROG_SIZE-1:0] prog_addr,
    input  logic [31:0]          prog_wdata,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [PROG_SIZE:0]   words_sent,
    output logic                 txd
);
    localparam int unsigned PS    = PROG_SIZE;
    localparam int unsigned WS    = PROG_SIZE + 1;
    localparam int unsigned DEPTH = 1 << PROG_SIZE;

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_FETCH, S_SEND, S_WAIT, S_TERM, S_FIN
    } state_t;

    state_t        state, state_n;
    logic [31:0]   shift_reg, shift_reg_n;
    logic          last, last_n;
    logic          in_sync, in_sync_n;
    logic          wait_first, wait_first_n;
    logic [1:0]    byte_cnt, byte_cnt_n;
    logic [PS-1:0] idx, idx_n;
    logic [WS-1:0] words_sent_n;
    logic          busy_n, done_n;
    logic          tx_start, tx_start_n;
    logic [7:0]    tx_data, tx_data_n;
    logic          tx_busy;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rdata;

    // Read address follows the next index so FETCH sees the new word
    always_ff @(posedge clk) begin
        if (prog_we && state == S_IDLE)
            mem[prog_addr] <= prog_wdata;
        rdata <= mem[idx_n];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            shift_reg  <= '0;
            last       <= 1'b0;
            in_sync    <= 1'b0;
            wait_first <= 1'b0;
            byte_cnt   <= '0;
            idx        <= '0;
            words_sent <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
        end else begin
            state      <= state_n;
            shift_reg  <= shift_reg_n;
            last       <= last_n;
            in_sync    <= in_sync_n;
            wait_first <= wait_first_n;
            byte_cnt   <= byte_cnt_n;
            idx        <= idx_n;
            words_sent <= words_sent_n;
            busy       <= busy_n;
            done       <= done_n;
            tx_start   <= tx_start_n;
            tx_data    <= tx_data_n;
        end
    end

    always_comb begin
        state_n      = state;
        shift_reg_n  = shift_reg;
        last_n       = last;
        in_sync_n    = in_sync;
        wait_first_n = wait_first;
        byte_cnt_n   = byte_cnt;
        idx_n        = idx;
        words_sent_n = words_sent;
        busy_n       = busy;
        done_n       = 1'b0;
        tx_start_n   = 1'b0;
        tx_data_n    = tx_data;

        unique case (state)
            S_IDLE: begin
                busy_n = 1'b0;
                if (start) begin
                    words_sent_n = '0;
                    idx_n        = '0;
                    in_sync_n    = 1'b1;
                    busy_n       = 1'b1;
                    state_n      = S_SYNC;
                end
            end
            S_SYNC: begin
                shift_reg_n = {8'hAA, 24'h0};
                byte_cnt_n  = '0;
                state_n     = S_SEND;
            end
            S_FETCH: begin
                shift_reg_n = rdata;
                last_n      = (rdata == 32'd0);
                byte_cnt_n  = '0;
                state_n     = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_start_n   = 1'b1;
                    tx_data_n    = shift_reg[31:24];
                    wait_first_n = 1'b1;
                    state_n      = S_WAIT;
                end
            end
            S_WAIT: begin
                // tx_busy only rises after the registered tx_start lands
                if (wait_first) begin
                    wait_first_n = 1'b0;
                end else if (!tx_busy) begin
                    shift_reg_n = {shift_reg[23:0], 8'h00};
                    if (in_sync) begin
                        in_sync_n = 1'b0;
                        state_n   = S_FETCH;
                    end else if (byte_cnt == 2'd3) begin
                        words_sent_n = words_sent + WS'(1);
                        byte_cnt_n   = '0;
                        if (last) begin
                            state_n = S_FIN;
                        end else if (idx == PS'(DEPTH - 1)) begin
                            state_n = S_TERM;
                        end else begin
                            idx_n   = idx + PS'(1);
                            state_n = S_FETCH;
                        end
                    end else begin
                        byte_cnt_n = byte_cnt + 2'd1;
                        state_n    = S_SEND;
                    end
                end
            end
            S_TERM: begin
                shift_reg_n = '0;
                last_n      = 1'b1;
                byte_cnt_n  = '0;
                state_n     = S_SEND;
            end
            S_FIN: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    uart_tx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_uart_tx (
        .clk      (clk),
        .rstn     (~rst),
        .tx_start (tx_start),
        .data     (tx_data),
        .tx_busy  (tx_busy),
        .txd      (txd)
    );
endmodule
